// File: rtl/disp_pkg.sv
// Shared types and helpers for the display frame scheduler.
// Frame width, scheduler state encoding and the overlay priority encoder.
package disp_pkg;

    localparam int DISP_W = 256;

    typedef logic [DISP_W-1:0] disp_frame_t;

    typedef enum logic {ST_BG, ST_OVL} sched_st_t;

    // Highest set index wins; returns 0 when nothing is set.
    function automatic logic [2:0] prio_hi(input logic [7:0] r);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/disp_frame_mux.sv
// Registered NREQ-way frame mux with blank gate; latency 1 clk, loads only on commit.
// No backpressure: frame is taken on the commit strobe, frame_upd flags a content change.
module disp_frame_mux
    import disp_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                   rst_n,
    input  logic                   clk,
    input  logic                   commit,
    input  logic                   blank,
    input  logic [2:0]             sel,
    input  logic [NREQ*DISP_W-1:0] frames,
    output logic [DISP_W-1:0]      disp_data,
    output logic                   frame_upd
);

    disp_frame_t disp_data_d, disp_data_q;
    logic        frame_upd_d, frame_upd_q;
    disp_frame_t frame_sel;
    disp_frame_t frame_next;

    always_comb begin
        frame_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == 3'(i)) frame_sel = frames[i*DISP_W +: DISP_W];
        end
        frame_next  = blank ? '0 : frame_sel;
        disp_data_d = commit ? frame_next : disp_data_q;
        frame_upd_d = commit && (frame_next != disp_data_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data_q <= '0;
            frame_upd_q <= 1'b0;
        end else begin
            disp_data_q <= disp_data_d;
            frame_upd_q <= frame_upd_d;
        end
    end

    assign disp_data = disp_data_q;
    assign frame_upd = frame_upd_q;

endmodule

// File: rtl/disp_sched.sv
// Display frame scheduler: background req 0, fixed-priority overlays with ms hold time.
// Latency: state and frame update on tsc_1ppms commits only; no backpressure, outputs registered.
module disp_sched
    import disp_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int HOLD_W = 16
) (
    input  logic                     rst_n,
    input  logic                     clk,
    input  logic                     tsc_1ppms,
    input  logic                     blank,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DISP_W-1:0]   req_data,
    input  logic [NREQ*HOLD_W-1:0]   req_hold_ms,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          grant_ack,
    output logic [2:0]               owner_id,
    output logic [DISP_W-1:0]        disp_data,
    output logic                     frame_upd
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    sched_st_t         st_d, st_q;
    logic [2:0]        owner_d, owner_q;
    logic [HOLD_W-1:0] hold_d, hold_q;
    logic [NREQ-1:0]   grant_d, grant_q;
    logic [NREQ-1:0]   ack_d, ack_q;

    logic [7:0]        req_ovl;
    logic              any_ovl;
    logic [2:0]        top_id;
    logic [HOLD_W-1:0] hold_sel;
    logic [HOLD_W-1:0] hold_reload;

    // Overlay arbitration; req 0 is masked since background is always eligible.
    always_comb begin
        req_ovl            = '0;
        req_ovl[NREQ-1:0]  = req;
        req_ovl[0]         = 1'b0;
        any_ovl            = |req_ovl;
        top_id             = prio_hi(req_ovl);
        hold_sel           = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (top_id == 3'(i)) hold_sel = req_hold_ms[i*HOLD_W +: HOLD_W];
        end
        hold_reload = (hold_sel == '0) ? '0 : hold_sel - HOLD_ONE;
    end

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        if (tsc_1ppms) begin
            case (st_q)
                ST_BG: begin
                    if (any_ovl) begin
                        st_d    = ST_OVL;
                        owner_d = top_id;
                        hold_d  = hold_reload;
                    end
                end
                default: begin
                    if (any_ovl && (top_id > owner_q)) begin
                        owner_d = top_id;
                        hold_d  = hold_reload;
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_ONE;
                    end else if (any_ovl) begin
                        owner_d = top_id;
                        hold_d  = hold_reload;
                    end else begin
                        st_d    = ST_BG;
                        owner_d = 3'd0;
                        hold_d  = '0;
                    end
                end
            endcase
        end

        for (int i = 0; i < NREQ; i++) begin
            grant_d[i] = (owner_d == 3'(i));
        end
        ack_d = (tsc_1ppms && (owner_d != owner_q)) ? grant_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_BG;
            owner_q <= 3'd0;
            hold_q  <= '0;
            grant_q <= NREQ'(1);
            ack_q   <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
        end
    end

    // The mux selects with the owner decided on this same commit.
    disp_frame_mux #(
        .NREQ (NREQ)
    ) u_frame_mux (
        .rst_n     (rst_n),
        .clk       (clk),
        .commit    (tsc_1ppms),
        .blank     (blank),
        .sel       (owner_d),
        .frames    (req_data),
        .disp_data (disp_data),
        .frame_upd (frame_upd)
    );

    assign grant     = grant_q;
    assign grant_ack = ack_q;
    assign owner_id  = owner_q;

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched: directed scenarios plus randomized commits against a ms-level reference model.
module tb_disp_sched;

    localparam int NREQ   = 3;
    localparam int HOLD_W = 16;
    localparam int DW     = 256;

    logic                   rst_n;
    logic                   clk;
    logic                   tsc_1ppms;
    logic                   blank;
    logic [NREQ-1:0]        req;
    logic [NREQ*DW-1:0]     req_data;
    logic [NREQ*HOLD_W-1:0] req_hold_ms;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        grant_ack;
    logic [2:0]             owner_id;
    logic [DW-1:0]          disp_data;
    logic                   frame_upd;

    int checks = 0;
    int errors = 0;

    // Reference model state (one step per committed ms)
    int              m_owner;
    int              m_hold;
    logic [DW-1:0]   m_data;
    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] exp_ack;
    logic            exp_upd;

    disp_sched #(.NREQ(NREQ), .HOLD_W(HOLD_W)) dut (
        .rst_n       (rst_n),
        .clk         (clk),
        .tsc_1ppms   (tsc_1ppms),
        .blank       (blank),
        .req         (req),
        .req_data    (req_data),
        .req_hold_ms (req_hold_ms),
        .grant       (grant),
        .grant_ack   (grant_ack),
        .owner_id    (owner_id),
        .disp_data   (disp_data),
        .frame_upd   (frame_upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // disp_data may only move on a commit edge or under reset.
    always @(disp_data) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (tsc_1ppms !== 1'b1) begin
                errors++;
                $display("FAIL stable_between_commits: disp_data changed at %0t without commit", $time);
            end
        end
    end

    function automatic logic [DW-1:0] rnd_frame();
        logic [DW-1:0] r;
        for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [DW-1:0] frame_of(int i);
        return req_data[i*DW +: DW];
    endfunction

    function automatic int hold_of(int i);
        int h;
        h = int'(req_hold_ms[i*HOLD_W +: HOLD_W]);
        return (h == 0) ? 0 : h - 1;
    endfunction

    task automatic model_reset();
        m_owner   = 0;
        m_hold    = 0;
        m_data    = '0;
        exp_grant = NREQ'(1);
        exp_ack   = '0;
        exp_upd   = 1'b0;
    endtask

    // One ms of scheduling, derived directly from the ownership rules.
    task automatic model_commit();
        int top;
        int prev_owner;
        logic [DW-1:0] prev_data;
        top = 0;
        for (int i = 1; i < NREQ; i++) if (req[i]) top = i;
        prev_owner = m_owner;
        prev_data  = m_data;
        if (m_owner == 0) begin
            if (top > 0) begin m_owner = top; m_hold = hold_of(top); end
        end else if (top > m_owner) begin
            m_owner = top; m_hold = hold_of(top);
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (top > 0) begin
            m_owner = top; m_hold = hold_of(top);
        end else begin
            m_owner = 0; m_hold = 0;
        end
        m_data    = blank ? '0 : frame_of(m_owner);
        exp_grant = NREQ'(1) << m_owner;
        exp_ack   = (m_owner != prev_owner) ? exp_grant : '0;
        exp_upd   = (m_data != prev_data);
    endtask

    task automatic do_commit();
        @(negedge clk);
        tsc_1ppms = 1'b1;
        model_commit();
        @(negedge clk);
        tsc_1ppms = 1'b0;
    endtask

    task automatic set_req(int i, logic on, int hold, logic [DW-1:0] f);
        req[i] = on;
        req_hold_ms[i*HOLD_W +: HOLD_W] = HOLD_W'(hold);
        req_data[i*DW +: DW] = f;
    endtask

    logic [DW-1:0] fa, fb, fc;

    task automatic test_reset();
        int upd_cnt;
        rst_n = 1'b0; tsc_1ppms = 1'b0; blank = 1'b0; req = '0;
        req_hold_ms = '0; req_data = '0;
        fa = rnd_frame();
        set_req(0, 1'b0, 0, fa);
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({grant, grant_ack, owner_id, frame_upd} !== {3'b001, 3'b000, 3'd0, 1'b0} || disp_data !== '0) begin
            errors++;
            $display("FAIL reset_state: grant=%b ack=%b owner=%0d upd=%b data0=%b exp 001/000/0/0/1",
                     grant, grant_ack, owner_id, frame_upd, disp_data == '0);
        end
        @(negedge clk) rst_n = 1'b1;
        upd_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            do_commit();
            checks++;
            if ({grant, grant_ack, owner_id, frame_upd} !== {exp_grant, exp_ack, 3'(m_owner), exp_upd}) begin
                errors++;
                $display("FAIL bg_ctl[%0d]: got g=%b a=%b o=%0d u=%b exp g=%b a=%b o=%0d u=%b", c,
                         grant, grant_ack, owner_id, frame_upd, exp_grant, exp_ack, m_owner, exp_upd);
            end
            if (frame_upd === 1'b1) upd_cnt++;
        end
        checks++;
        if (disp_data !== fa || upd_cnt != 1) begin
            errors++;
            $display("FAIL bg_frame: data_is_A=%b upd_cnt=%0d exp 1/1", disp_data === fa, upd_cnt);
        end
    endtask

    task automatic test_hold();
        int own_cnt, ack_cnt;
        fb = rnd_frame();
        set_req(1, 1'b1, 3, fb);
        own_cnt = 0; ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            do_commit();
            if (c == 0) req[1] = 1'b0;
            checks++;
            if ({grant, grant_ack, owner_id, frame_upd} !== {exp_grant, exp_ack, 3'(m_owner), exp_upd} ||
                disp_data !== m_data) begin
                errors++;
                $display("FAIL hold_step[%0d]: got o=%0d a=%b u=%b exp o=%0d a=%b u=%b", c,
                         owner_id, grant_ack, frame_upd, m_owner, exp_ack, exp_upd);
            end
            if (owner_id == 3'd1 && disp_data === fb) own_cnt++;
            if (grant_ack[1] === 1'b1) ack_cnt++;
        end
        checks++;
        if (own_cnt != 3 || ack_cnt != 1 || disp_data !== fa) begin
            errors++;
            $display("FAIL hold_total: own_cnt=%0d ack_cnt=%0d back_to_A=%b exp 3/1/1",
                     own_cnt, ack_cnt, disp_data === fa);
        end
    endtask

    task automatic test_preempt();
        fc = rnd_frame();
        set_req(1, 1'b1, 10, fb);
        repeat (5) do_commit();
        set_req(2, 1'b1, 2, fc);
        do_commit();
        req[2] = 1'b0;
        checks++;
        if (owner_id !== 3'd2 || disp_data !== fc || grant_ack !== 3'b100) begin
            errors++;
            $display("FAIL preempt: owner=%0d ack=%b data_is_C=%b exp 2/100/1",
                     owner_id, grant_ack, disp_data === fc);
        end
        repeat (2) do_commit();
        checks++;
        if (owner_id !== 3'd1 || disp_data !== fb || grant_ack !== 3'b010) begin
            errors++;
            $display("FAIL preempt_return: owner=%0d ack=%b data_is_B=%b exp 1/010/1",
                     owner_id, grant_ack, disp_data === fb);
        end
        req[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            do_commit();
            checks++;
            if (owner_id !== 3'(m_owner) || grant !== exp_grant || disp_data !== m_data) begin
                errors++;
                $display("FAIL preempt_drain[%0d]: owner=%0d exp %0d", c, owner_id, m_owner);
            end
        end
    endtask

    task automatic test_zero_hold();
        int ack_cnt;
        set_req(1, 1'b1, 0, fb);
        do_commit();
        req[1] = 1'b0;
        do_commit();
        checks++;
        if (owner_id !== 3'd0 || disp_data !== fa) begin
            errors++;
            $display("FAIL zero_hold_single: owner=%0d data_is_A=%b exp 0/1", owner_id, disp_data === fa);
        end
        req[1] = 1'b1;
        ack_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            do_commit();
            if (grant_ack[1] === 1'b1) ack_cnt++;
        end
        checks++;
        if (owner_id !== 3'd1 || ack_cnt != 1 || frame_upd !== 1'b0) begin
            errors++;
            $display("FAIL zero_hold_stay: owner=%0d ack_cnt=%0d upd=%b exp 1/1/0", owner_id, ack_cnt, frame_upd);
        end
        req[1] = 1'b0;
        do_commit();
        checks++;
        if (owner_id !== 3'(m_owner) || grant_ack !== exp_ack) begin
            errors++;
            $display("FAIL zero_hold_release: owner=%0d ack=%b exp %0d/%b", owner_id, grant_ack, m_owner, exp_ack);
        end
    endtask

    task automatic test_blank();
        set_req(2, 1'b1, 5, fc);
        do_commit();
        blank = 1'b1;
        do_commit();
        checks++;
        if (disp_data !== '0 || owner_id !== 3'd2 || frame_upd !== 1'b1 || grant_ack !== 3'b000) begin
            errors++;
            $display("FAIL blank_on: data0=%b owner=%0d upd=%b ack=%b exp 1/2/1/000",
                     disp_data == '0, owner_id, frame_upd, grant_ack);
        end
        blank = 1'b0;
        do_commit();
        checks++;
        if (disp_data !== fc || owner_id !== 3'd2 || frame_upd !== 1'b1) begin
            errors++;
            $display("FAIL blank_off: data_is_C=%b owner=%0d upd=%b exp 1/2/1", disp_data === fc, owner_id, frame_upd);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 3'b001 || owner_id !== 3'd0 || disp_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: grant=%b owner=%0d data0=%b exp 001/0/1", grant, owner_id, disp_data == '0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req[2] = 1'b0;
        do_commit();
        checks++;
        if (owner_id !== 3'd0 || disp_data !== fa || frame_upd !== 1'b1 || grant_ack !== 3'b000) begin
            errors++;
            $display("FAIL reset_first_commit: owner=%0d data_is_A=%b upd=%b ack=%b exp 0/1/1/000",
                     owner_id, disp_data === fa, frame_upd, grant_ack);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 150; it++) begin
            req = NREQ'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NREQ; i++) begin
                req_hold_ms[i*HOLD_W +: HOLD_W] = HOLD_W'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) req_data[i*DW +: DW] = rnd_frame();
            end
            do_commit();
            checks++;
            if ({grant, grant_ack, owner_id, frame_upd} !== {exp_grant, exp_ack, 3'(m_owner), exp_upd} ||
                disp_data !== m_data) begin
                errors++;
                $display("FAIL rand_commit[%0d]: got g=%b a=%b o=%0d u=%b exp g=%b a=%b o=%0d u=%b data_ok=%b", it,
                         grant, grant_ack, owner_id, frame_upd, exp_grant, exp_ack, m_owner, exp_upd,
                         disp_data === m_data);
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                req_data[$urandom_range(0, NREQ-1)*DW +: DW] = rnd_frame();
                @(negedge clk);
                checks++;
                if (frame_upd !== 1'b0 || grant_ack !== '0 || disp_data !== m_data || grant !== exp_grant) begin
                    errors++;
                    $display("FAIL rand_idle[%0d]: upd=%b ack=%b grant=%b data_ok=%b", it,
                             frame_upd, grant_ack, grant, disp_data === m_data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_preempt();
        test_zero_hold();
        test_blank();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
